// File: rtl/tarsier_pkg.sv
// Types and default sizes shared between the column buffer and the x-moment stage.
package tarsier_pkg;

   localparam int DEF_LUMA_BITS     = 8;
   localparam int DEF_WINDOW_SIZE_Y = 5;

   typedef logic [DEF_LUMA_BITS-1:0] luma_t;
   typedef luma_t column_t [DEF_WINDOW_SIZE_Y];

endpackage

// File: rtl/line_memory.sv
// One stored image line: single address, read-before-write, registered read data.
// old_data exposes the pre-write word so the line above can be shifted down in the same cycle.
module line_memory #(
   parameter int LUMA_BITS = 8,
   parameter int DEPTH     = 640,
   parameter int AW        = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 in_reset_n,
   input  logic                 en,
   input  logic [AW-1:0]        addr,
   input  logic [LUMA_BITS-1:0] wr_data,
   output logic [LUMA_BITS-1:0] old_data,
   output logic [LUMA_BITS-1:0] rd_data
);

   logic [LUMA_BITS-1:0] mem [DEPTH];
   logic [LUMA_BITS-1:0] rd_d, rd_q;

   assign old_data = mem[addr];
   assign rd_data  = rd_q;

   always_comb begin
      rd_d = rd_q;
      if (en) rd_d = old_data;
   end

   // Only the read register is reset; stale array words are flushed by re-priming.
   always_ff @(posedge clk) begin
      if (!in_reset_n) rd_q <= '0;
      else             rd_q <= rd_d;
   end

   always_ff @(posedge clk) begin
      if (en) mem[addr] <= wr_data;
   end

endmodule

// File: rtl/column_buffer.sv
// Raster-to-column converter: keeps WINDOW_SIZE_Y-1 previous lines and emits one vertical
// column per accepted pixel, one cycle later, once enough rows have been primed.
module column_buffer
   import tarsier_pkg::*;
#(
   parameter int LUMA_BITS     = DEF_LUMA_BITS,
   parameter int WINDOW_SIZE_Y = DEF_WINDOW_SIZE_Y,
   parameter int IMAGE_WIDTH   = 640
) (
   input  logic                 clk,
   input  logic                 in_reset_n,
   input  logic                 in_valid,
   input  logic                 in_sof,
   input  logic [LUMA_BITS-1:0] in_pixel,
   output logic [LUMA_BITS-1:0] out_column [WINDOW_SIZE_Y],
   output logic                 out_valid,
   output logic                 out_row_start
);

   localparam int XW    = $clog2(IMAGE_WIDTH);
   localparam int YW    = $clog2(WINDOW_SIZE_Y);
   localparam int LINES = WINDOW_SIZE_Y - 1;

   logic [XW-1:0]        x_d, x_q, eff_x;
   logic [YW-1:0]        y_d, y_q, eff_y;
   logic                 valid_d, valid_q;
   logic                 row_start_d, row_start_q;
   logic [LUMA_BITS-1:0] pixel_d, pixel_q;
   logic                 mem_en;

   logic [LUMA_BITS-1:0] line_old [LINES];
   logic [LUMA_BITS-1:0] line_rd  [LINES];

   // A pixel presented during reset is dropped, so it must not touch the lines either.
   assign mem_en = in_valid && in_reset_n;

   always_comb begin
      eff_x       = in_sof ? '0 : x_q;
      eff_y       = in_sof ? '0 : y_q;
      x_d         = x_q;
      y_d         = y_q;
      valid_d     = 1'b0;
      row_start_d = 1'b0;
      pixel_d     = pixel_q;
      if (in_valid) begin
         pixel_d     = in_pixel;
         valid_d     = (eff_y == YW'(WINDOW_SIZE_Y - 1));
         row_start_d = valid_d && (eff_x == '0);
         y_d         = eff_y;
         if (eff_x == XW'(IMAGE_WIDTH - 1)) begin
            x_d = '0;
            if (eff_y != YW'(WINDOW_SIZE_Y - 1)) y_d = eff_y + YW'(1);
         end else begin
            x_d = eff_x + XW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!in_reset_n) begin
         x_q         <= '0;
         y_q         <= '0;
         valid_q     <= 1'b0;
         row_start_q <= 1'b0;
         pixel_q     <= '0;
      end else begin
         x_q         <= x_d;
         y_q         <= y_d;
         valid_q     <= valid_d;
         row_start_q <= row_start_d;
         pixel_q     <= pixel_d;
      end
   end

   // Line k takes line k+1's pre-write word; the newest line takes the incoming pixel.
   for (genvar k = 0; k < LINES; k++) begin : g_line
      logic [LUMA_BITS-1:0] wr_data;
      if (k == LINES - 1) begin : g_top
         assign wr_data = in_pixel;
      end else begin : g_mid
         assign wr_data = line_old[k+1];
      end

      line_memory #(
         .LUMA_BITS (LUMA_BITS),
         .DEPTH     (IMAGE_WIDTH),
         .AW        (XW)
      ) u_line (
         .clk        (clk),
         .in_reset_n (in_reset_n),
         .en         (mem_en),
         .addr       (eff_x),
         .wr_data    (wr_data),
         .old_data   (line_old[k]),
         .rd_data    (line_rd[k])
      );

      assign out_column[k] = line_rd[k];
   end

   assign out_column[WINDOW_SIZE_Y-1] = pixel_q;
   assign out_valid                   = valid_q;
   assign out_row_start               = row_start_q;

endmodule

// File: tb/tb_column_buffer.sv
// Directed bench for column_buffer with an 8-pixel-wide image and a 5-row column.
module tb_column_buffer;

   logic       clk = 1'b0;
   logic       in_reset_n;
   logic       in_valid;
   logic       in_sof;
   logic [7:0] in_pixel;
   logic [7:0] out_column [5];
   logic       out_valid;
   logic       out_row_start;

   int passed = 0;
   int total  = 0;

   wire [39:0] col = {out_column[0], out_column[1], out_column[2], out_column[3], out_column[4]};

   column_buffer #(.LUMA_BITS(8), .WINDOW_SIZE_Y(5), .IMAGE_WIDTH(8)) dut (
      .clk           (clk),
      .in_reset_n    (in_reset_n),
      .in_valid      (in_valid),
      .in_sof        (in_sof),
      .in_pixel      (in_pixel),
      .out_column    (out_column),
      .out_valid     (out_valid),
      .out_row_start (out_row_start)
   );

   always #5 clk = ~clk;

   // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
   task automatic drive(input logic rst_n, input logic v, input logic sof, input logic [7:0] pix);
      in_reset_n = rst_n;
      in_valid   = v;
      in_sof     = sof;
      in_pixel   = pix;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      drive(1'b0, 1'b1, 1'b0, 8'hAA);
      drive(1'b0, 1'b1, 1'b1, 8'h55);
      total++;
      if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid);
      else passed++;
      total++;
      if (out_row_start !== 1'b0) $display("FAIL reset_row_start got %b want 0", out_row_start);
      else passed++;
      total++;
      if (col !== 40'h0) $display("FAIL reset_column got %h want 0000000000", col);
      else passed++;
   endtask

   task automatic test_priming;
      int early = 0;
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 8; x++) begin
            drive(1'b1, 1'b1, (x == 0 && y == 0), 8'(y*16 + x));
            if (out_valid !== 1'b0) early++;
         end
      total++;
      if (early != 0) $display("FAIL priming_no_valid got %0d valid cycles want 0", early);
      else passed++;
      drive(1'b1, 1'b1, 1'b0, 8'h40);
      total++;
      if (out_valid !== 1'b1 || out_row_start !== 1'b1)
         $display("FAIL first_col_flags got v=%b rs=%b want v=1 rs=1", out_valid, out_row_start);
      else passed++;
      total++;
      if (col !== 40'h0010203040) $display("FAIL first_col_data got %h want 0010203040", col);
      else passed++;
   endtask

   task automatic test_bubbles;
      int bad = 0;
      for (int x = 1; x < 5; x++) drive(1'b1, 1'b1, 1'b0, 8'(8'h40 + x));
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b0, 8'hEE);
         if (out_valid !== 1'b0 || out_row_start !== 1'b0 || col !== 40'h0414243444) bad++;
      end
      total++;
      if (bad != 0) $display("FAIL bubble_hold got %0d bad cycles col=%h want 0 col=0414243444", bad, col);
      else passed++;
      drive(1'b1, 1'b1, 1'b0, 8'h45);
      total++;
      if (out_valid !== 1'b1 || col !== 40'h0515253545)
         $display("FAIL after_bubble got v=%b col=%h want v=1 col=0515253545", out_valid, col);
      else passed++;
      drive(1'b1, 1'b1, 1'b0, 8'h46);
      drive(1'b1, 1'b1, 1'b0, 8'h47);
      total++;
      if (out_row_start !== 1'b0 || col !== 40'h0717273747)
         $display("FAIL last_col got rs=%b col=%h want rs=0 col=0717273747", out_row_start, col);
      else passed++;
   endtask

   task automatic test_row_wrap;
      int nvalid = 0;
      int nrs    = 0;
      drive(1'b1, 1'b1, 1'b0, 8'h50);
      total++;
      if (out_row_start !== 1'b1 || col !== 40'h1020304050)
         $display("FAIL wrap_first got rs=%b col=%h want rs=1 col=1020304050", out_row_start, col);
      else passed++;
      nvalid += int'(out_valid);
      nrs    += int'(out_row_start);
      for (int x = 1; x < 8; x++) begin
         drive(1'b1, 1'b1, 1'b0, 8'(8'h50 + x));
         nvalid += int'(out_valid);
         nrs    += int'(out_row_start);
      end
      total++;
      if (nvalid != 8 || nrs != 1)
         $display("FAIL wrap_count got valid=%0d rs=%0d want valid=8 rs=1", nvalid, nrs);
      else passed++;
      total++;
      if (col !== 40'h1727374757) $display("FAIL wrap_last got %h want 1727374757", col);
      else passed++;
   endtask

   task automatic test_sof_midframe;
      int early = 0;
      for (int x = 0; x < 3; x++) drive(1'b1, 1'b1, 1'b0, 8'(8'h60 + x));
      // New frame begins at pixel 0x63; later new-frame pixels follow y*16+x.
      for (int n = 0; n < 32; n++) begin
         drive(1'b1, 1'b1, (n == 0), (n == 0) ? 8'h63 : 8'((n/8)*16 + n%8));
         if (out_valid !== 1'b0) early++;
      end
      total++;
      if (early != 0) $display("FAIL sof_priming got %0d valid cycles want 0", early);
      else passed++;
      drive(1'b1, 1'b1, 1'b0, 8'h40);
      total++;
      if (out_valid !== 1'b1 || out_row_start !== 1'b1)
         $display("FAIL sof_first_flags got v=%b rs=%b want v=1 rs=1", out_valid, out_row_start);
      else passed++;
      total++;
      if (col !== 40'h6310203040) $display("FAIL sof_first_data got %h want 6310203040", col);
      else passed++;
   endtask

   task automatic test_reset_midrow;
      int early = 0;
      for (int x = 1; x < 8; x++) drive(1'b1, 1'b1, 1'b0, 8'(8'h40 + x));
      for (int x = 0; x < 3; x++) drive(1'b1, 1'b1, 1'b0, 8'(8'h50 + x));
      drive(1'b0, 1'b1, 1'b0, 8'h53);
      total++;
      if (out_valid !== 1'b0 || out_row_start !== 1'b0 || col !== 40'h0)
         $display("FAIL midrow_reset got v=%b rs=%b col=%h want v=0 rs=0 col=0000000000",
                  out_valid, out_row_start, col);
      else passed++;
      for (int n = 0; n < 32; n++) begin
         drive(1'b1, 1'b1, 1'b0, 8'((n/8)*16 + n%8));
         if (out_valid !== 1'b0) early++;
      end
      total++;
      if (early != 0) $display("FAIL reprime got %0d valid cycles want 0", early);
      else passed++;
      drive(1'b1, 1'b1, 1'b0, 8'h40);
      total++;
      if (out_valid !== 1'b1 || out_row_start !== 1'b1 || col !== 40'h0010203040)
         $display("FAIL reprime_first got v=%b rs=%b col=%h want v=1 rs=1 col=0010203040",
                  out_valid, out_row_start, col);
      else passed++;
   endtask

   initial begin
      in_reset_n = 1'b0;
      in_valid   = 1'b0;
      in_sof     = 1'b0;
      in_pixel   = 8'h00;
      test_reset();
      test_priming();
      test_bubbles();
      test_row_wrap();
      test_sof_midframe();
      test_reset_midrow();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
